// File: rtl/data_memory_sync_if.sv
// Request/response bus between the datapath and data_memory_sync.
//   req    : access request (master -> slave), sampled only while ready=1
//   we     : 1 = write, 0 = read
//   addr   : word address (ADDR_W bits)
//   wdata  : write data (DATA_W bits)
//   rdata  : read data, valid while rvalid=1; holds otherwise
//   rvalid : one-cycle read-response strobe
//   ready  : memory accepts requests (initialisation finished)
//   err    : one-cycle strobe, previous accepted access was out of range
interface data_memory_sync_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              ready;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  rdata, rvalid, ready, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, rvalid, ready, err
    );
endinterface

// File: rtl/data_memory_sync.sv
// Clocked data memory for the 8-bit datapath.
// After reset a sequencer fills every word (zero, or its own index), then the
// memory accepts one request per cycle: synchronous writes and latency-1 reads
// with a valid strobe. Accesses with addr >= DEPTH are flagged on err; such
// writes are dropped and such reads return zero.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of data_memory_sync_if (req/we/addr/wdata in,
//           rdata/rvalid/ready/err out)
module data_memory_sync #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 12,
    parameter int INIT_MODE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    data_memory_sync_if.slave  bus
);
    generate
        if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
            $error("data_memory_sync: DEPTH must lie in 1..2**ADDR_W");
        end
    endgenerate

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EXT_W = (CNT_W > DATA_W) ? CNT_W : DATA_W;
    localparam logic [ADDR_W:0]  DEPTH_V = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              ready_q;
    logic              err_q;

    logic              in_range;
    logic              mem_we;
    logic [IDX_W-1:0]  acc_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] init_val;
    logic [EXT_W-1:0]  cnt_ext;

    always_comb begin
        // Widen before slicing so the init value zero-extends or truncates
        // the counter to DATA_W regardless of which is wider.
        cnt_ext  = EXT_W'(cnt);
        init_val = (INIT_MODE != 0) ? cnt_ext[DATA_W-1:0] : '0;
        in_range = {1'b0, bus.addr} < DEPTH_V;
        acc_idx  = IDX_W'(bus.addr);
        if (state == S_INIT) begin
            // Held off while in reset so the array is only touched by the
            // sequencer once reset is released.
            mem_we  = rst_n;
            mem_idx = IDX_W'(cnt);
            mem_wd  = init_val;
        end else begin
            mem_we  = bus.req && bus.we && in_range;
            mem_idx = acc_idx;
            mem_wd  = bus.wdata;
        end
    end

    // Storage array: no reset, contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_INIT;
            cnt      <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            case (state)
                S_INIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state   <= S_RUN;
                        ready_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.req) begin
                        err_q <= !in_range;
                        if (!bus.we) begin
                            rvalid_q <= 1'b1;
                            rdata_q  <= in_range ? mem[acc_idx] : '0;
                        end
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.ready  = ready_q;
    assign bus.err    = err_q;
endmodule
